// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU with IDLE/EXEC/DONE control.
// Single-cycle ops finish one cycle after acceptance. Multiply (shift-add) and
// divide (restoring) take WIDTH cycles. The done pulse follows one edge after DONE.
// Optional divider: define ALU_SEQ_DIV_EN to build it. Without the macro,
// opcode 110 completes at once with result=0, result_hi=0, carry_out=1.
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_CEQ = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q;   // mul: partial product high half; div: remainder
  logic [WIDTH-1:0] lo_q;   // mul: multiplier shifting out; div: dividend/quotient
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] s_res, s_hi;
  logic             s_cy;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] mul_next;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff, div_rem_next, div_q_next;
  logic             div_ge;
`endif

  // Single-cycle results, from the operands latched at acceptance.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    s_res = '0;
    s_hi  = '0;
    s_cy  = 1'b0;
    case (op_q)
      OP_ADD: {s_cy, s_res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        s_res = a_q - b_q;
        s_cy  = (a_q < b_q);
      end
      OP_AND: s_res = a_q & b_q;
      OP_OR:  s_res = a_q | b_q;
      OP_XOR: s_res = a_q ^ b_q;
      OP_MUL: s_res = '0;
      OP_DIV: begin
        // Divide by zero (or no divider built): flag the error.
`ifdef ALU_SEQ_DIV_EN
        s_hi = a_q;
`endif
        s_cy = 1'b1;
      end
      OP_CEQ: s_res = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
    endcase
  end

  // One shift-add multiply step: conditionally add A, then shift right.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, lo_q[WIDTH-1:1]};
  end

`ifdef ALU_SEQ_DIV_EN
  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    div_shift    = {hi_q, lo_q[WIDTH-1]};
    div_ge       = (div_shift >= {1'b0, b_q});
    div_diff     = div_shift[WIDTH-1:0] - b_q;
    div_rem_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_q_next   = {lo_q[WIDTH-2:0], div_ge};
  end
`endif

  // Control FSM, datapath registers and registered outputs.
  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= opcode;
            a_q   <= a;
            b_q   <= b;
            hi_q  <= '0;
            lo_q  <= (opcode == OP_DIV) ? a : b;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op_q == OP_MUL) begin
            {hi_q, lo_q} <= mul_next;
            cnt          <= cnt + 1'b1;
            if (cnt == LAST_STEP) begin
              result    <= mul_next[WIDTH-1:0];
              result_hi <= mul_next[2*WIDTH-1:WIDTH];
              carry_out <= |mul_next[2*WIDTH-1:WIDTH];
              zero      <= (mul_next[WIDTH-1:0] == '0);
              state     <= DONE;
            end
`ifdef ALU_SEQ_DIV_EN
          end else if (op_q == OP_DIV && b_q != '0) begin
            hi_q <= div_rem_next;
            lo_q <= div_q_next;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_STEP) begin
              result    <= div_q_next;
              result_hi <= div_rem_next;
              carry_out <= 1'b0;
              zero      <= (div_q_next == '0);
              state     <= DONE;
            end
`endif
          end else begin
            result    <= s_res;
            result_hi <= s_hi;
            carry_out <= s_cy;
            zero      <= (s_res == '0);
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (WIDTH=8): directed cases plus random
// operations compared against an arithmetic reference model.
module tb_alu_seq_core;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   opcode;
  logic [W-1:0] a, b;
  logic         busy, done, carry_out, zero;
  logic [W-1:0] result, result_hi;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .carry_out(carry_out), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's definition.
  task automatic model(input int op, input int x, input int y,
                       output int res, output int hi, output int cy, output int lat);
    int p;
    res = 0; hi = 0; cy = 0; lat = 2;
    case (op)
      0: begin p = x + y; res = p % 256; cy = (p > 255); end
      1: begin res = (x - y + 256) % 256; cy = (x < y); end
      2: res = x & y;
      3: res = x | y;
      4: res = x ^ y;
      5: begin p = x * y; res = p % 256; hi = p / 256; cy = (hi != 0); lat = W + 1; end
      6: begin
`ifdef ALU_SEQ_DIV_EN
        if (y == 0) begin res = 0; hi = x; cy = 1; end
        else begin res = x / y; hi = x % y; cy = 0; lat = W + 1; end
`else
        res = 0; hi = 0; cy = 1;
`endif
      end
      default: res = (x == y) ? 1 : 0;
    endcase
  endtask

  // Issue one operation, scramble inputs afterwards, optionally pulse start
  // again mid-operation, then check latency, outputs and that done pulses once.
  task automatic do_op(input int op, input int x, input int y, input bit poke, input string tag);
    int cyc, e_res, e_hi, e_cy, e_lat, extra;
    model(op, x, y, e_res, e_hi, e_cy, e_lat);
    @(negedge clk);
    opcode = 3'(op); a = W'(x); b = W'(y); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; opcode = 3'($urandom); a = W'($urandom); b = W'($urandom);
    check({tag, ".busy_start"}, 32'(busy), 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      start = (poke && cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, ".latency"}, 32'(cyc), 32'(e_lat));
    check({tag, ".result"}, 32'(result), 32'(e_res));
    check({tag, ".result_hi"}, 32'(result_hi), 32'(e_hi));
    check({tag, ".carry"}, 32'(carry_out), 32'(e_cy));
    check({tag, ".zero"}, 32'(zero), 32'(e_res == 0));
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    extra = 0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    check({tag, ".single_done"}, 32'(extra), 32'd0);
    check({tag, ".hold"}, 32'(result), 32'(e_res));
  endtask

  initial begin
    int extra;
    reset = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.result_hi", 32'(result_hi), 32'd0);
    check("rst.carry", 32'(carry_out), 32'd0);
    check("rst.zero", 32'(zero), 32'd0);

    // Reset wins over start on the same edge.
    start = 1'b1; opcode = 3'd0; a = 8'd1; b = 8'd1;
    @(posedge clk); #1;
    check("rst_prio.busy", 32'(busy), 32'd0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst_prio.idle", 32'(busy), 32'd0);

    do_op(0, 200, 100, 1'b0, "add200_100");
    do_op(5, 255, 255, 1'b0, "mul255");
    do_op(6, 100, 7, 1'b0, "div100_7");
    do_op(6, 100, 0, 1'b0, "div100_0");
    do_op(6, 9, 3, 1'b0, "div9_3");
    do_op(1, 5, 5, 1'b0, "sub5_5");
    do_op(1, 3, 10, 1'b0, "sub_borrow");
    do_op(5, 13, 11, 1'b1, "mul_poke");
    do_op(7, 42, 42, 1'b0, "ceq_eq");
    do_op(7, 42, 43, 1'b0, "ceq_ne");

    // Reset four cycles into a multiply aborts it.
    @(negedge clk);
    opcode = 3'd5; a = 8'd77; b = 8'd99; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.result_hi", 32'(result_hi), 32'd0);
    extra = 0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    check("abort.no_done", 32'(extra), 32'd0);
    do_op(0, 1, 2, 1'b0, "add_after_abort");

    for (int i = 0; i < 40; i++) begin
      int op, x, y;
      op = int'($urandom_range(0, 7));
      x  = int'($urandom_range(0, 255));
      y  = (i % 8 == 0) ? 0 : int'($urandom_range(0, 255));
      do_op(op, x, y, 1'b0, $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 Parameter WIDTH, default 8: operand, result and register width; legal values 4..32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled only on the rising edge of clk.
REQ-004 start  input  1  request pulse; sampled only while busy is low.
REQ-005 opcode  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 div, 111 compare-equal.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking result valid.
REQ-010 result  output  WIDTH  registered primary result (sum, difference, logic result, product low half, quotient, compare).
REQ-011 result_hi  output  WIDTH  registered product high half for mul, remainder for div, zero otherwise.
REQ-012 carry_out  output  1  registered carry/borrow/overflow/error flag.
REQ-013 zero  output  1  registered, high when result is all zeros.

Function
REQ-014 State machine SHALL have states IDLE, EXEC, DONE.
REQ-015 IDLE: start=1 latches opcode, a, b into internal registers and moves to EXEC; start=0 stays in IDLE.
REQ-016 EXEC, opcodes 000-100, 111, and div with b=0: result computed in one cycle, then DONE.
REQ-017 EXEC, mul: shift-add, exactly WIDTH cycles counted by a log2(WIDTH)+1-bit counter, then DONE.
REQ-018 EXEC, div with b!=0: restoring division, exactly WIDTH cycles, then DONE.
REQ-019 DONE: done=1 for exactly one cycle; next state is always IDLE.
REQ-020 Latency, start sampled at edge 0: done high after edge 2 for single-cycle ops; after edge WIDTH+1 for mul and div.
REQ-021 start while busy is high is ignored; it is not queued.
REQ-022 Input changes after the start edge do not affect the operation in progress.
REQ-023 result, result_hi, carry_out and zero update only on entry to DONE; they hold until the next DONE or reset.
REQ-024 add: {carry_out,result} = a+b, WIDTH+1 bits.
REQ-025 sub: result = a-b mod 2^WIDTH; carry_out = 1 iff a<b, unsigned borrow.
REQ-026 and/or/xor: bitwise; carry_out=0.
REQ-027 compare: result = 1 if a==b else 0; carry_out=0.
REQ-028 mul: unsigned 2*WIDTH-bit product {result_hi,result}; carry_out = OR of result_hi bits.
REQ-029 div, b!=0: result = a/b; result_hi = a%b; carry_out=0.
REQ-030 div, b=0: result=0; result_hi=a; carry_out=1.

Reset
REQ-031 reset=1 at any edge, including mid-EXEC or in DONE, SHALL force IDLE, abort the operation and clear the counter and all outputs to 0 (busy=0, done=0).
REQ-032 Reset has priority over start in the same cycle; no operation is accepted on that edge.

Configuration
REQ-033 Macro ALU_SEQ_DIV_EN defined: div behaves per REQ-018, REQ-029 and REQ-030.
REQ-034 Macro ALU_SEQ_DIV_EN undefined: no divider logic is built; opcode 110 completes in one cycle with result=0, result_hi=0, carry_out=1.

Verification (WIDTH=8)
REQ-035 add a=200, b=100 -> done 2 cycles after start; result=44, carry_out=1, zero=0.
REQ-036 mul a=255, b=255 -> done after 9 cycles; result_hi=0xFE, result=0x01, carry_out=1.
REQ-037 div a=100, b=7 (ALU_SEQ_DIV_EN) -> done after 9 cycles; result=14, result_hi=2, carry_out=0. Same stimulus with b=0 -> done after 2 cycles; result=0, result_hi=100, carry_out=1.
REQ-038 sub a=5, b=5 -> result=0, zero=1, carry_out=0. A second start pulse during a mul -> ignored; exactly one done pulse.
REQ-039 reset asserted 4 cycles into a mul -> IDLE on the next edge; busy=0, no done pulse; a following add a=1, b=2 -> result=3.
REQ-040 Build without ALU_SEQ_DIV_EN, div a=9, b=3 -> done after 2 cycles; result=0, carry_out=1.
